// File: rtl/mac_pkg.sv
// Shared sizing and saturation-limit helpers for the MAC dot-product unit.
package mac_pkg;

  function automatic int unsigned prod_w(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

  // Limits returned as raw ACC_W-bit patterns in the low bits of a 64-bit word.
  function automatic logic [63:0] sat_max(input int unsigned acc_w, input bit is_signed);
    return is_signed ? ((64'd1 << (acc_w - 1)) - 64'd1) : ((64'd1 << acc_w) - 64'd1);
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned acc_w, input bit is_signed);
    return is_signed ? (64'd1 << (acc_w - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational accumulator adder with optional saturation and overflow flag.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W    = 12,
  parameter int unsigned P_W      = 8,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [P_W-1:0]   p,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam int unsigned SW = ACC_W + 1;

  logic [SW-1:0] acc_x;
  logic [SW-1:0] p_x;
  logic [SW-1:0] raw;

  // One guard bit is enough to detect overflow of a single add.
  always_comb begin
    if (SIGNED) begin
      acc_x = SW'($signed(acc));
      p_x   = SW'($signed(p));
    end else begin
      acc_x = SW'(acc);
      p_x   = SW'(p);
    end
    raw = acc_x + p_x;
    ovf = SIGNED ? (raw[SW-1] ^ raw[SW-2]) : raw[SW-1];
    sum = raw[ACC_W-1:0];
    if (ovf && SATURATE) begin
      if (SIGNED && raw[SW-1]) sum = ACC_W'(sat_min(ACC_W, SIGNED));
      else                     sum = ACC_W'(sat_max(ACC_W, SIGNED));
    end
  end

endmodule

// File: rtl/mac_dotprod_unit.sv
// Pipelined multiply-accumulate engine: sums VEC_LEN products per vector, one result per vector.
module mac_dotprod_unit
  import mac_pkg::*;
#(
  parameter int unsigned A_W      = 4,
  parameter int unsigned B_W      = 4,
  parameter int unsigned ACC_W    = 12,
  parameter int unsigned VEC_LEN  = 4,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned P_W   = prod_w(A_W, B_W);
  localparam int unsigned CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  if (ACC_W < P_W) begin : g_acc_w_check
    $error("mac_dotprod_unit: ACC_W must be >= A_W+B_W");
  end
  if (VEC_LEN < 1) begin : g_vec_len_check
    $error("mac_dotprod_unit: VEC_LEN must be >= 1");
  end

  logic             adv;
  logic             accept;
  logic             last_c;
  logic [CNT_W-1:0] cnt;

  logic             s1_valid;
  logic             s1_last;
  logic [A_W-1:0]   s1_a;
  logic [B_W-1:0]   s1_b;

  logic             s2_valid;
  logic             s2_last;
  logic [P_W-1:0]   s2_p;
  logic [P_W-1:0]   prod_c;

  logic [ACC_W-1:0] acc;
  logic             ovf_sticky;
  logic [ACC_W-1:0] sum_c;
  logic             ovf_c;

  // A held result freezes the whole pipeline until the sink takes it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign last_c   = (cnt == CNT_LAST);
  assign busy     = s1_valid || s2_valid || (cnt != '0);

  if (SIGNED) begin : g_mul_signed
    assign prod_c = P_W'($signed(s1_a)) * P_W'($signed(s1_b));
  end else begin : g_mul_unsigned
    assign prod_c = P_W'(s1_a) * P_W'(s1_b);
  end

  mac_sat_add #(
    .ACC_W   (ACC_W),
    .P_W     (P_W),
    .SIGNED  (SIGNED),
    .SATURATE(SATURATE)
  ) u_sat_add (
    .acc(acc),
    .p  (s2_p),
    .sum(sum_c),
    .ovf(ovf_c)
  );

  // Operand, product and accumulate stages plus output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      s2_p       <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_acc    <= '0;
      out_ovf    <= 1'b0;
    end else if (clr) begin
      cnt        <= '0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_acc    <= '0;
      out_ovf    <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_last <= last_c;
        cnt     <= last_c ? '0 : cnt + CNT_W'(1);
      end
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      s2_p      <= prod_c;
      out_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        if (s2_last) begin
          out_acc    <= sum_c;
          out_ovf    <= ovf_sticky || ovf_c;
          acc        <= '0;
          ovf_sticky <= 1'b0;
        end else begin
          acc        <= sum_c;
          ovf_sticky <= ovf_sticky || ovf_c;
        end
      end
    end
  end

endmodule
